// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types: deframer states, scan codes and joypad bit positions.
// The joypad indices are also used by the FF00 register logic.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_Z      = 8'h1A;
  localparam logic [7:0] SC_X      = 8'h22;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;

  localparam logic [2:0] JP_RIGHT  = 3'd0;
  localparam logic [2:0] JP_LEFT   = 3'd1;
  localparam logic [2:0] JP_UP     = 3'd2;
  localparam logic [2:0] JP_DOWN   = 3'd3;
  localparam logic [2:0] JP_A      = 3'd4;
  localparam logic [2:0] JP_B      = 3'd5;
  localparam logic [2:0] JP_SELECT = 3'd6;
  localparam logic [2:0] JP_START  = 3'd7;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_hit_t;

  // Arrow keys only count when preceded by E0; their keypad twins are ignored.
  function automatic key_hit_t map_key(input logic [7:0] code, input logic ext);
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = JP_RIGHT;
    if (ext) begin
      case (code)
        SC_RIGHT: r.idx = JP_RIGHT;
        SC_LEFT:  r.idx = JP_LEFT;
        SC_UP:    r.idx = JP_UP;
        SC_DOWN:  r.idx = JP_DOWN;
        default:  r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_Z:      r.idx = JP_A;
        SC_X:      r.idx = JP_B;
        SC_ENTER:  r.idx = JP_START;
        SC_RSHIFT: r.idx = JP_SELECT;
        default:   r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the PS/2 pins and debounces the device clock; emits a one-cycle
// pulse on each filtered falling edge together with the synchronised data.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic dat,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt;
  logic [CW-1:0] cnt;

  // NOTE: all state here uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 1'b1;
      cnt      <= '0;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      fall     <= 1'b0;
      // Level flips only on the FILTER_LEN-th consecutive differing sample.
      if (clk_sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= clk_sync[1];
        cnt  <= '0;
        fall <= filt;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign dat = dat_sync[1];

endmodule

// File: rtl/ps2_joypad_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, reports scan codes and keeps
// the GameBoy joypad pressed-state vector from make/break codes.
module ps2_joypad_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic [7:0] joypad
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          dat;
  logic          fall;
  state_t        state, state_next;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] to_cnt;
  logic          brk_flag, ext_flag;
  logic          accept, bad, timeout;
  key_hit_t      key;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .dat     (dat),
    .fall    (fall)
  );

  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    bad        = 1'b0;
    timeout    = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    key        = map_key(shreg, ext_flag);
    case (state)
      IDLE:    if (fall && !dat) state_next = DATA;
      DATA:    if (fall && bit_cnt == 3'd7) state_next = PARITY;
      PARITY:  if (fall) state_next = STOP;
      STOP: begin
        if (fall) begin
          if (dat && ^{shreg, par}) accept = 1'b1;
          else                      bad    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (timeout) state_next = IDLE;
  end

  // NOTE: reset is synchronous; every register, including the shift register, is cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      to_cnt     <= '0;
      brk_flag   <= 1'b0;
      ext_flag   <= 1'b0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      joypad     <= '0;
    end else begin
      state      <= state_next;
      scan_valid <= accept;
      frame_err  <= bad | timeout;

      if (state == IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + TW'(1);

      if (fall) begin
        case (state)
          IDLE:    bit_cnt <= '0;
          DATA: begin
            shreg   <= {dat, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY:  par <= dat;
          default: ;
        endcase
      end

      if (accept) begin
        scan_code <= shreg;
        if (shreg == SC_BREAK) begin
          brk_flag <= 1'b1;
        end else if (shreg == SC_EXT) begin
          ext_flag <= 1'b1;
        end else begin
          if (key.hit) joypad[key.idx] <= ~brk_flag;
          brk_flag <= 1'b0;
          ext_flag <= 1'b0;
        end
      end

      if (bad | timeout) begin
        brk_flag <= 1'b0;
        ext_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_joypad_rx.sv
// Directed bench for ps2_joypad_rx: drives PS/2 frames at a 200-clk bit period
// and compares outputs against hand-computed values.
module tb_ps2_joypad_rx;

  localparam int FL   = 4;
  localparam int TO   = 2000;
  localparam int HALF = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;
  logic [7:0] joypad;

  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int err_cyc = 0;
  int overlap = 0;
  int errors = 0;
  int checks = 0;

  ps2_joypad_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_err  (frame_err),
    .joypad     (joypad)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (scan_valid) n_valid++;
    if (frame_err) begin
      n_err++;
      err_cyc = cyc;
    end
    if (scan_valid && frame_err) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  // Sends the first n bits of a frame; t_last is the cycle of the last clock fall.
  task automatic send_bits(input logic [10:0] bits, input int n, output int t_last);
    t_last = 0;
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      idle(HALF / 2);
      ps2_clk = 1'b0;
      t_last  = cyc;
      idle(HALF);
      ps2_clk = 1'b1;
      idle(HALF / 2);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par = 1'b0);
    int t;
    send_bits(frame(b, bad_par), 11, t);
    ps2_dat = 1'b1;
    idle(20);
  endtask

  initial begin
    int v0, e0, t;
    reset   = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    idle(5);
    check("rst_scan_code", scan_code, 8'h00);
    check("rst_scan_valid", scan_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_joypad", joypad, 8'h00);
    reset = 1'b0;
    idle(10);

    // Z make: A pressed
    v0 = n_valid; e0 = n_err;
    send_byte(8'h1A);
    check("z_valid_cnt", n_valid - v0, 1);
    check("z_scan_code", scan_code, 8'h1A);
    check("z_joypad", joypad, 8'h10);
    check("z_err_cnt", n_err - e0, 0);

    // Extended up make then break
    v0 = n_valid;
    send_byte(8'hE0);
    send_byte(8'h75);
    check("up_make_joypad", joypad, 8'h14);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("up_break_joypad", joypad, 8'h10);
    check("up_valid_cnt", n_valid - v0, 5);
    check("up_scan_code", scan_code, 8'h75);

    // Parity error
    v0 = n_valid; e0 = n_err;
    send_byte(8'h5A, 1'b1);
    check("par_err_cnt", n_err - e0, 1);
    check("par_valid_cnt", n_valid - v0, 0);
    check("par_scan_code", scan_code, 8'h75);
    check("par_joypad", joypad, 8'h10);

    // Break prefix, then a stalled frame that must time out
    send_byte(8'hF0);
    e0 = n_err;
    send_bits(frame(8'h5A, 1'b0), 4, t);
    idle(2500);
    check("to_err_cnt", n_err - e0, 1);
    // 2 sync + FL filter cycles to the fall, 1 to process it, then TO cycles
    check("to_latency", err_cyc - t, 2 + FL + 1 + TO);
    send_byte(8'h5A);
    check("to_brk_cleared_joypad", joypad, 8'h90);
    send_byte(8'hF0);
    send_byte(8'h5A);
    check("to_start_break_joypad", joypad, 8'h10);

    // Short glitches on an idle line
    v0 = n_valid; e0 = n_err;
    for (int k = 0; k < 4; k++) begin
      ps2_clk = 1'b0;
      idle(3);
      ps2_clk = 1'b1;
      idle(20);
    end
    check("glitch_valid_cnt", n_valid - v0, 0);
    check("glitch_err_cnt", n_err - e0, 0);
    send_byte(8'h22);
    check("glitch_next_joypad", joypad, 8'h30);
    check("glitch_next_valid_cnt", n_valid - v0, 1);
    check("glitch_next_err_cnt", n_err - e0, 0);
    send_byte(8'h22);
    check("typematic_joypad", joypad, 8'h30);
    send_byte(8'h74);
    check("keypad_unmapped_joypad", joypad, 8'h30);
    check("keypad_scan_code", scan_code, 8'h74);

    // Press everything, then reset mid-frame
    send_byte(8'h5A);
    send_byte(8'h59);
    send_byte(8'hE0); send_byte(8'h74);
    send_byte(8'hE0); send_byte(8'h6B);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h72);
    check("all_joypad", joypad, 8'hFF);
    send_bits(frame(8'h22, 1'b0), 5, t);
    reset = 1'b1;
    idle(1);
    check("mid_rst_scan_code", scan_code, 8'h00);
    check("mid_rst_scan_valid", scan_valid, 1'b0);
    check("mid_rst_frame_err", frame_err, 1'b0);
    check("mid_rst_joypad", joypad, 8'h00);
    reset   = 1'b0;
    ps2_dat = 1'b1;
    e0 = n_err;
    idle(50);
    send_byte(8'h22);
    check("post_rst_joypad", joypad, 8'h20);
    check("post_rst_scan_code", scan_code, 8'h22);
    check("post_rst_err_cnt", n_err - e0, 0);

    check("valid_err_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
